// File: rtl/neander_pkg.sv
// Shared definitions for the Neander control unit: opcodes, ALU selects,
// sequencer states and small decode helpers.
package neander_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned OP_W           = 4;

    // Opcode nibble (IR[7:4])
    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_STA = 4'h1;
    localparam logic [OP_W-1:0] OP_LDA = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_NOT = 4'h6;
    localparam logic [OP_W-1:0] OP_JMP = 4'h8;
    localparam logic [OP_W-1:0] OP_JN  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // External ALU select codes; they coincide with IR[6:4] of the opcodes
    localparam logic [2:0] ALU_SEL_PASS = 3'b010;
    localparam logic [2:0] ALU_SEL_ADD  = 3'b011;
    localparam logic [2:0] ALU_SEL_OR   = 3'b100;
    localparam logic [2:0] ALU_SEL_AND  = 3'b101;
    localparam logic [2:0] ALU_SEL_NOT  = 3'b110;

    typedef enum logic [2:0] {
        ST_FETCH_OP   = 3'd0,
        ST_DECODE     = 3'd1,
        ST_FETCH_ADDR = 3'd2,
        ST_READ       = 3'd3,
        ST_ALU        = 3'd4,
        ST_WRITE      = 3'd5,
        ST_HALT       = 3'd6
    } state_e;

    // Instructions carrying an address operand byte
    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        return (op == OP_STA) || (op == OP_LDA) || (op == OP_ADD) ||
               (op == OP_OR)  || (op == OP_AND) || (op == OP_JMP) ||
               (op == OP_JN)  || (op == OP_JZ);
    endfunction

    // Instructions that read a data operand and commit through the ALU
    function automatic logic is_mem_alu(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_OR) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/neander_control.sv
// Neander CPU sequencer and register set (PC, IR, REM, RDM, AC, N, Z).
// Talks to memory over a req/ack port and to an external 8-bit ALU.
// Optional single-step input enabled by defining NEANDER_STEP_EN.
module neander_control
    import neander_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
`ifdef NEANDER_STEP_EN
    input  logic              i_STEP,
`endif
    output logic              o_MEM_REQ,
    output logic              o_MEM_WE,
    output logic [DATA_W-1:0] o_MEM_ADDR,
    output logic [DATA_W-1:0] o_MEM_WDATA,
    input  logic              i_MEM_ACK,
    input  logic [DATA_W-1:0] i_MEM_RDATA,
    output logic [DATA_W-1:0] o_ALU_A,
    output logic [DATA_W-1:0] o_ALU_B,
    output logic [2:0]        o_ALU_SEL,
    input  logic [DATA_W-1:0] i_ALU_OUT,
    input  logic              i_ALU_ZERO,
    input  logic              i_ALU_NEG,
    output logic [DATA_W-1:0] o_AC,
    output logic              o_N,
    output logic              o_Z,
    output logic              o_HALTED
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   op_q, op_d;       // IR: only the opcode nibble is ever decoded
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] rdm_q, rdm_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic              n_q, n_d;
    logic              z_q, z_d;
    logic              halted_q, halted_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
`ifdef NEANDER_STEP_EN
    logic              armed_q, armed_d;  // step sampled, fetch may proceed
`endif

    logic xfer_c;
    logic take_jump_c;

    assign xfer_c      = mem_req_q & i_MEM_ACK;
    assign take_jump_c = (op_q == OP_JMP) || ((op_q == OP_JN) && n_q) || ((op_q == OP_JZ) && z_q);

    // Next-state, register-set updates and next memory-port outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        rem_d    = rem_q;
        rdm_d    = rdm_q;
        ac_d     = ac_q;
        n_d      = n_q;
        z_d      = z_q;

        unique case (state_q)
            ST_FETCH_OP: begin
                if (xfer_c) begin
                    op_d    = i_MEM_RDATA[DATA_W-1 -: OP_W];
                    pc_d    = pc_q + DATA_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_q == OP_NOT) begin
                    ac_d    = i_ALU_OUT;
                    n_d     = i_ALU_NEG;
                    z_d     = i_ALU_ZERO;
                    state_d = ST_FETCH_OP;
                end else if (op_q == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (is_two_byte(op_q)) begin
                    state_d = ST_FETCH_ADDR;
                end else begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_ADDR: begin
                if (xfer_c) begin
                    rem_d = i_MEM_RDATA;
                    pc_d  = take_jump_c ? i_MEM_RDATA : pc_q + DATA_W'(1);
                    if (is_mem_alu(op_q)) begin
                        state_d = ST_READ;
                    end else if (op_q == OP_STA) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FETCH_OP;
                    end
                end
            end
            ST_READ: begin
                if (xfer_c) begin
                    rdm_d   = i_MEM_RDATA;
                    state_d = ST_ALU;
                end
            end
            ST_ALU: begin
                ac_d    = i_ALU_OUT;
                n_d     = i_ALU_NEG;
                z_d     = i_ALU_ZERO;
                state_d = ST_FETCH_OP;
            end
            ST_WRITE: begin
                if (xfer_c) begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH_OP;
            end
        endcase

        // Memory-port outputs are a function of the state being entered
`ifdef NEANDER_STEP_EN
        armed_d   = (state_q == ST_FETCH_OP) && (state_d == ST_FETCH_OP) && (armed_q || i_STEP);
        mem_req_d = (state_d == ST_FETCH_OP) ? armed_d
                                             : (state_d inside {ST_FETCH_ADDR, ST_READ, ST_WRITE});
`else
        mem_req_d = state_d inside {ST_FETCH_OP, ST_FETCH_ADDR, ST_READ, ST_WRITE};
`endif
        mem_we_d   = (state_d == ST_WRITE);
        mem_addr_d = (state_d inside {ST_FETCH_OP, ST_FETCH_ADDR}) ? pc_d : rem_d;
        halted_d   = (state_d == ST_HALT);
    end

    // State and register set; reset abandons any outstanding request
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= ST_FETCH_OP;
            pc_q       <= RESET_PC;
            op_q       <= '0;
            rem_q      <= '0;
            rdm_q      <= '0;
            ac_q       <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b1;
            halted_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= RESET_PC;
`ifdef NEANDER_STEP_EN
            armed_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            rdm_q      <= rdm_d;
            ac_q       <= ac_d;
            n_q        <= n_d;
            z_q        <= z_d;
            halted_q   <= halted_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
`ifdef NEANDER_STEP_EN
            armed_q    <= armed_d;
`endif
        end
    end

    assign o_MEM_REQ   = mem_req_q;
    assign o_MEM_WE    = mem_we_q;
    assign o_MEM_ADDR  = mem_addr_q;
    assign o_MEM_WDATA = ac_q;
    assign o_ALU_A     = ac_q;
    assign o_ALU_B     = rdm_q;
    assign o_ALU_SEL   = op_q[2:0];
    assign o_AC        = ac_q;
    assign o_N         = n_q;
    assign o_Z         = z_q;
    assign o_HALTED    = halted_q;

endmodule

// File: tb/tb_neander_control.sv
// Self-checking bench for neander_control: memory responder with
// programmable ack latency, behavioural ALU, and an instruction-level
// reference model predicting every memory transfer, cycle count and final state.
module tb_neander_control;
    import neander_pkg::*;

`ifdef NEANDER_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       step;
    logic       req, we, ack;
    logic [7:0] addr, wdata, rdata;
    logic [7:0] alu_a, alu_b, alu_out, ac;
    logic [2:0] alu_sel;
    logic       alu_zero, alu_neg, n_flag, z_flag, halted;

    logic [7:0]  mem   [256];
    logic [7:0]  m_mem [256];
    int unsigned dly   [1024];
    xfer_t       exp_q [$];

    int          n_checks, n_pass;
    int          xfer_idx, wait_cnt, cyc;
    bit          in_req;
    logic [7:0]  cap_addr, cap_wdata;
    logic        cap_we;
    int          m_cycles;
    logic [7:0]  m_ac;
    logic        m_n, m_z, m_halt;

    always #5 clk = ~clk;

    neander_control #(.DATA_W(8), .RESET_PC(8'h00)) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
`ifdef NEANDER_STEP_EN
        .i_STEP      (step),
`endif
        .o_MEM_REQ   (req),
        .o_MEM_WE    (we),
        .o_MEM_ADDR  (addr),
        .o_MEM_WDATA (wdata),
        .i_MEM_ACK   (ack),
        .i_MEM_RDATA (rdata),
        .o_ALU_A     (alu_a),
        .o_ALU_B     (alu_b),
        .o_ALU_SEL   (alu_sel),
        .i_ALU_OUT   (alu_out),
        .i_ALU_ZERO  (alu_zero),
        .i_ALU_NEG   (alu_neg),
        .o_AC        (ac),
        .o_N         (n_flag),
        .o_Z         (z_flag),
        .o_HALTED    (halted)
    );

    // External ALU
    always_comb begin
        case (alu_sel)
            ALU_SEL_PASS: alu_out = alu_b;
            ALU_SEL_ADD:  alu_out = alu_a + alu_b;
            ALU_SEL_OR:   alu_out = alu_a | alu_b;
            ALU_SEL_AND:  alu_out = alu_a & alu_b;
            ALU_SEL_NOT:  alu_out = ~alu_a;
            default:      alu_out = 8'h00;
        endcase
    end
    assign alu_zero = (alu_out == 8'h00);
    assign alu_neg  = alu_out[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    endtask

    // Memory responder: ack after the programmed number of wait cycles,
    // random ack noise while no request is pending
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ack    = 1'b0;
            in_req = 1'b0;
        end else if (req) begin
            if (!in_req) begin
                in_req    = 1'b1;
                cap_addr  = addr;
                cap_we    = we;
                cap_wdata = wdata;
            end
            if (wait_cnt == 0) begin
                ack   = 1'b1;
                rdata = mem[addr];
            end else begin
                ack      = 1'b0;
                wait_cnt = wait_cnt - 1;
                rdata    = 8'($urandom);
            end
        end else begin
            ack   = 1'($urandom_range(0, 1));
            rdata = 8'($urandom);
        end
    end

    // Transfer monitor: compare each completed transfer with the model trace
    initial forever begin
        xfer_t e;
        @(posedge clk);
        if (rst_n) begin
            if (!halted) cyc = cyc + 1;
            if (req && ack) begin
                if (xfer_idx < exp_q.size()) begin
                    e = exp_q[xfer_idx];
                    check($sformatf("xfer%0d_we", xfer_idx), 32'(we), 32'(e.we));
                    check($sformatf("xfer%0d_addr", xfer_idx), 32'(addr), 32'(e.addr));
                    if (e.we) check($sformatf("xfer%0d_wdata", xfer_idx), 32'(wdata), 32'(e.data));
                end else begin
                    check("xfer_extra", 32'(xfer_idx), 32'(exp_q.size()));
                end
                check($sformatf("xfer%0d_hold_addr", xfer_idx), 32'(addr), 32'(cap_addr));
                check($sformatf("xfer%0d_hold_we", xfer_idx), 32'(we), 32'(cap_we));
                if (we) begin
                    check($sformatf("xfer%0d_hold_wdata", xfer_idx), 32'(wdata), 32'(cap_wdata));
                    mem[addr] = wdata;
                end
                xfer_idx = xfer_idx + 1;
                wait_cnt = int'(dly[xfer_idx % 1024]);
                in_req   = 1'b0;
            end
        end
    end

    function automatic bit tb_two_byte(input logic [3:0] op);
        return op inside {OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP, OP_JN, OP_JZ};
    endfunction

    task automatic exp_push(input logic w, input logic [7:0] a, input logic [7:0] d);
        m_cycles += int'(dly[exp_q.size() % 1024]);
        exp_q.push_back('{we: w, addr: a, data: d});
    endtask

    // Instruction-level model: architectural effect, transfer trace, cycle budget
    task automatic model();
        logic [7:0] pc, acc, opnd, v;
        logic       n, z;
        int         base;
        exp_q.delete();
        pc = 8'h00; acc = 8'h00; n = 1'b0; z = 1'b1; opnd = 8'h00;
        m_halt = 1'b0; m_cycles = 1;
        for (int k = 0; k < 4000 && !m_halt; k++) begin
            v = m_mem[pc];
            exp_push(1'b0, pc, 8'h00);
            pc = pc + 8'h01;
            if (tb_two_byte(v[7:4])) begin
                opnd = m_mem[pc];
                exp_push(1'b0, pc, 8'h00);
                pc = pc + 8'h01;
            end
            base = 2;
            case (v[7:4])
                OP_STA: begin exp_push(1'b1, opnd, acc); m_mem[opnd] = acc; base = 4; end
                OP_LDA: begin exp_push(1'b0, opnd, 8'h00); acc = m_mem[opnd]; base = 5; end
                OP_ADD: begin exp_push(1'b0, opnd, 8'h00); acc = acc + m_mem[opnd]; base = 5; end
                OP_OR:  begin exp_push(1'b0, opnd, 8'h00); acc = acc | m_mem[opnd]; base = 5; end
                OP_AND: begin exp_push(1'b0, opnd, 8'h00); acc = acc & m_mem[opnd]; base = 5; end
                OP_NOT: acc = ~acc;
                OP_JMP: begin pc = opnd; base = 3; end
                OP_JN:  begin if (n) pc = opnd; base = 3; end
                OP_JZ:  begin if (z) pc = opnd; base = 3; end
                OP_HLT: m_halt = 1'b1;
                default: ;
            endcase
            if (v[7:4] inside {OP_LDA, OP_ADD, OP_OR, OP_AND, OP_NOT}) begin
                n = acc[7];
                z = (acc == 8'h00);
            end
            m_cycles += base + ((STEP_MODE && k > 0) ? 1 : 0);
        end
        m_ac = acc; m_n = n; m_z = z;
    endtask

    task automatic set_delays(input int mode);
        for (int i = 0; i < 1024; i++)
            dly[i] = (mode == 0) ? 0 : (mode == 1) ? 3 : $urandom_range(0, 3);
    endtask

    task automatic clear_mem(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) mem[i] = fill;
    endtask

    // Snapshot memory, predict, then reset and release the DUT
    task automatic prep();
        for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
        model();
        @(negedge clk);
        rst_n    = 1'b0;
        xfer_idx = 0;
        wait_cnt = int'(dly[0]);
        cyc      = 0;
        in_req   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input string name);
        int diffs, reqs;
        prep();
        for (int i = 0; i < m_cycles + 40 && !halted; i++) @(negedge clk);
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_cycles"}, 32'(cyc), 32'(m_cycles));
        check({name, "_nxfer"}, 32'(xfer_idx), 32'(exp_q.size()));
        check({name, "_ac"}, 32'(ac), 32'(m_ac));
        check({name, "_n"}, 32'(n_flag), 32'(m_n));
        check({name, "_z"}, 32'(z_flag), 32'(m_z));
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
        check({name, "_memdiff"}, 32'(diffs), 32'd0);
        reqs = 0;
        repeat (5) begin @(negedge clk); if (req) reqs++; end
        check({name, "_req_after_hlt"}, 32'(reqs), 32'd0);
    endtask

    task automatic gen_random();
        int         nins, pos, j;
        int         starts [25];
        logic [3:0] ops    [24];
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 128; i++) mem[i] = 8'hF0;
        nins = $urandom_range(10, 20);
        pos  = 0;
        for (int i = 0; i < nins; i++) begin
            ops[i]    = 4'($urandom_range(0, 14));
            starts[i] = pos;
            pos      += tb_two_byte(ops[i]) ? 2 : 1;
        end
        starts[nins] = pos;
        for (int i = 0; i < nins; i++) begin
            mem[8'(starts[i])] = {ops[i], 4'($urandom)};
            if (ops[i] inside {OP_JMP, OP_JN, OP_JZ}) begin
                j = $urandom_range(i + 1, nins);
                mem[8'(starts[i] + 1)] = 8'(starts[j]);
            end else if (tb_two_byte(ops[i])) begin
                mem[8'(starts[i] + 1)] = 8'h80 + 8'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        bit found;
        int reqs;
        n_checks = 0; n_pass = 0;
        ack = 1'b0; rdata = 8'h00; step = 1'b1;
        xfer_idx = 0; wait_cnt = 0; cyc = 0; in_req = 1'b0;
        set_delays(0);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_req", 32'(req), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_ac", 32'(ac), 32'd0);
        check("rst_n", 32'(n_flag), 32'd0);
        check("rst_z", 32'(z_flag), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);

        // LDA 80; ADD 81; STA 82; HLT  (5 + 0xFB wraps to 0)
        clear_mem(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h30; mem[3] = 8'h81;
        mem[4] = 8'h10; mem[5] = 8'h82; mem[6] = 8'hF0;
        mem[8'h80] = 8'h05; mem[8'h81] = 8'hFB; mem[8'h82] = 8'h77;
        run_prog("add_sta");
        check("add_sta_mem82", 32'(mem[8'h82]), 32'h00);
        check("add_sta_zflag", 32'(z_flag), 32'd1);

        // JN taken to 0x10 where NOT runs, and JN not taken
        clear_mem(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h10;
        mem[8'h10] = 8'h60; mem[8'h90] = 8'h80;
        run_prog("jn_taken");
        check("jn_taken_ac", 32'(ac), 32'h7F);
        mem[8'h90] = 8'h01;
        run_prog("jn_fall");
        check("jn_fall_ac", 32'(ac), 32'h01);

        // JZ taken, then NOT of 0x0F
        clear_mem(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h91; mem[2] = 8'hA0; mem[3] = 8'h20;
        mem[8'h20] = 8'h20; mem[8'h21] = 8'h92; mem[8'h22] = 8'h60;
        mem[8'h91] = 8'h00; mem[8'h92] = 8'h0F;
        run_prog("jz_not");
        check("jz_not_ac", 32'(ac), 32'hF0);
        check("jz_not_n", 32'(n_flag), 32'd1);

        // Three wait cycles on every transfer
        set_delays(1);
        clear_mem(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h85; mem[8'h85] = 8'hC3;
        run_prog("slow_lda");
        check("slow_lda_ac", 32'(ac), 32'hC3);

        // PC wrap 0xFF -> 0x00, opcode 0xB0 as NOP
        set_delays(2);
        clear_mem(8'hF0);
        mem[0] = 8'hA0; mem[1] = 8'hFE; mem[8'hFE] = 8'hB0; mem[8'hFF] = 8'h60;
        run_prog("wrap");
        check("wrap_ac", 32'(ac), 32'hFF);

        // Random forward-only programs with random ack latency
        for (int r = 0; r < 8; r++) begin
            set_delays((r < 2) ? 0 : 2);
            gen_random();
            run_prog($sformatf("rnd%0d", r));
        end

        // Reset while a READ is waiting for its ack
        set_delays(0);
        dly[2] = 60;
        clear_mem(8'hF0);
        mem[0] = 8'h20; mem[1] = 8'h80; mem[8'h80] = 8'h5A;
        prep();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (req && !we && addr == 8'h80) found = 1'b1;
        end
        check("midread_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midread_req_drop", 32'(req), 32'd0);
        check("midread_ac", 32'(ac), 32'd0);
        dly[2] = 0;
        run_prog("midread_restart");
        check("midread_restart_ac", 32'(ac), 32'h5A);

`ifdef NEANDER_STEP_EN
        // One instruction per step pulse
        clear_mem(8'hF0);
        mem[0] = {OP_NOP, 4'h0}; mem[1] = {OP_NOP, 4'h0};
        step = 1'b0;
        prep();
        reqs = 0;
        repeat (8) begin @(negedge clk); if (req) reqs++; end
        check("step_idle_req", 32'(reqs), 32'd0);
        for (int p = 1; p <= 2; p++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (10) @(negedge clk);
            check($sformatf("step%0d_xfers", p), 32'(xfer_idx), 32'(p));
            check($sformatf("step%0d_req", p), 32'(req), 32'd0);
        end
        step = 1'b1;
`else
        reqs = 0;
        check("free_run_step_unused", 32'(reqs), 32'(step) - 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
